// File: rtl/jk_register_bank_pkg.sv
// Shared constants for the JK register bank: mode encodings and the
// per-cell JK control encodings.
package jk_register_bank_pkg;

   // Operating modes selected by the mode port
   typedef enum logic [1:0] {
      MODE_JK    = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_COUNT = 2'b10,
      MODE_SHIFT = 2'b11
   } mode_e;

   // JK cell control pairs {j,k}
   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_CLEAR  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage : jk_register_bank_pkg

// File: rtl/jk_register_bank_cell.sv
// Single JK flip-flop bit cell with clock enable and asynchronous
// active-low reset to a per-cell reset value.
module jk_flipflop_cell
   import jk_register_bank_pkg::*;
#(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic q_r;

   // JK state update: hold, clear, set or toggle on enabled edges
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q_r <= RESET_VALUE;
      end else if (enable) begin
         case ({j, k})
            JK_HOLD:   q_r <= q_r;
            JK_CLEAR:  q_r <= 1'b0;
            JK_SET:    q_r <= 1'b1;
            JK_TOGGLE: q_r <= ~q_r;
            default:   q_r <= q_r;
         endcase
      end else begin
         q_r <= q_r;
      end
   end

   assign q    = q_r;
   assign qbar = ~q_r;

endmodule : jk_flipflop_cell

// File: rtl/jk_register_bank.sv
// Bank of JK bit cells. Every mode (JK, LOAD, COUNT, SHIFT) is expressed
// purely as per-cell j/k controls; the cells hold all of q. Two flag
// registers report count wrap and any change of q.
module jk_register_bank
   import jk_register_bank_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             carry_out,
   output logic             changed
);

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] qbar_s;
   logic [WIDTH-1:0] j_s;
   logic [WIDTH-1:0] k_s;
   logic [WIDTH-1:0] toggle_s;
   logic [WIDTH-1:0] low_mask_s;
   logic [WIDTH-1:0] shifted_s;
   logic [WIDTH-1:0] next_s;
   logic             carry_r;
   logic             changed_r;

   // Synchronous-counter toggle enables: bit i toggles when all lower bits are 1
   always_comb begin
      toggle_s   = {WIDTH{1'b0}};
      low_mask_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         low_mask_s  = ({{(WIDTH-1){1'b0}}, 1'b1} << i) - {{(WIDTH-1){1'b0}}, 1'b1};
         toggle_s[i] = &(q_s | ~low_mask_s);
      end
   end

   assign shifted_s = {q_s[WIDTH-2:0], serial_in};

   // Map the selected mode onto per-cell j/k controls
   always_comb begin
      j_s = {WIDTH{1'b0}};
      k_s = {WIDTH{1'b0}};
      case (mode)
         MODE_JK: begin
            j_s = j;
            k_s = k;
         end
         MODE_LOAD: begin
            j_s = d;
            k_s = ~d;
         end
         MODE_COUNT: begin
            j_s = toggle_s;
            k_s = toggle_s;
         end
         MODE_SHIFT: begin
            j_s = shifted_s;
            k_s = ~shifted_s;
         end
         default: begin
            j_s = {WIDTH{1'b0}};
            k_s = {WIDTH{1'b0}};
         end
      endcase
   end

   // Value the cells will take at the next enabled edge (JK characteristic equation)
   assign next_s = (j_s & ~q_s) | (~k_s & q_s);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_flipflop_cell #(
         .RESET_VALUE(RESET_VALUE[gi])
      ) u_cell (
         .clock   (clock),
         .reset_n (reset_n),
         .enable  (enable),
         .j       (j_s[gi]),
         .k       (k_s[gi]),
         .q       (q_s[gi]),
         .qbar    (qbar_s[gi])
      );
   end

   // Status pulses: count wrap and q-changed, cleared on disabled edges and reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         carry_r   <= 1'b0;
         changed_r <= 1'b0;
      end else if (enable) begin
         carry_r   <= (mode == MODE_COUNT) && (&q_s);
         changed_r <= (next_s != q_s);
      end else begin
         carry_r   <= 1'b0;
         changed_r <= 1'b0;
      end
   end

   assign q         = q_s;
   assign qbar      = qbar_s;
   assign carry_out = carry_r;
   assign changed   = changed_r;

endmodule : jk_register_bank

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench for jk_register_bank (WIDTH=4): a driver applies
// directed then random stimulus and pushes reference-model expectations;
// a monitor pops and compares after every rising edge.
module tb_jk_register_bank;
   import jk_register_bank_pkg::*;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic [1:0] mode;
   logic [3:0] j;
   logic [3:0] k;
   logic [3:0] d;
   logic       serial_in;
   logic [3:0] q;
   logic [3:0] qbar;
   logic       carry_out;
   logic       changed;

   typedef struct packed {
      logic [3:0] q;
      logic       carry;
      logic       changed;
   } exp_t;

   exp_t exp_fifo[$];
   int   checks   = 0;
   int   failures = 0;
   logic [3:0] mq;

   jk_register_bank #(
      .WIDTH(4),
      .RESET_VALUE(4'h0)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (enable),
      .mode      (mode),
      .j         (j),
      .k         (k),
      .d         (d),
      .serial_in (serial_in),
      .q         (q),
      .qbar      (qbar),
      .carry_out (carry_out),
      .changed   (changed)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_reset_now(input string tag);
      chk({tag, "_q"}, 32'(q), 32'h0);
      chk({tag, "_qbar"}, 32'(qbar), 32'hF);
      chk({tag, "_carry"}, 32'(carry_out), 32'h0);
      chk({tag, "_changed"}, 32'(changed), 32'h0);
   endtask

   // rst: 0 none, 1 reset pulse before the edge, 2 reset held across the edge
   task automatic step(input logic en, input logic [1:0] m, input logic [3:0] jj,
                       input logic [3:0] kk, input logic [3:0] dd, input logic si,
                       input int rst);
      exp_t       e;
      logic [3:0] nq;
      @(negedge clock);
      reset_n   = 1'b1;
      enable    = en;
      mode      = m;
      j         = jj;
      k         = kk;
      d         = dd;
      serial_in = si;
      if (rst != 0) begin
         #1 reset_n = 1'b0;
         #1 check_reset_now("async_reset");
         mq = 4'h0;
         if (rst == 1) #1 reset_n = 1'b1;
      end
      if (rst == 2) begin
         e = '{q: 4'h0, carry: 1'b0, changed: 1'b0};
      end else if (!en) begin
         e = '{q: mq, carry: 1'b0, changed: 1'b0};
      end else begin
         nq = mq;
         case (m)
            2'd0: for (int b = 0; b < 4; b++) begin
                     if (jj[b] && kk[b])      nq[b] = ~mq[b];
                     else if (jj[b])          nq[b] = 1'b1;
                     else if (kk[b])          nq[b] = 1'b0;
                  end
            2'd1: nq = dd;
            2'd2: nq = mq + 4'd1;
            default: nq = {mq[2:0], si};
         endcase
         e  = '{q: nq, carry: (m == 2'd2) && (mq == 4'hF), changed: (nq != mq)};
         mq = nq;
      end
      exp_fifo.push_back(e);
   endtask

   // Monitor: compare DUT outputs after each rising edge against the queued expectation
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_fifo.size() > 0) begin
            e = exp_fifo.pop_front();
            chk("q", 32'(q), 32'(e.q));
            chk("qbar", 32'(qbar), 32'(4'(~e.q)));
            chk("carry_out", 32'(carry_out), 32'(e.carry));
            chk("changed", 32'(changed), 32'(e.changed));
         end
      end
   end

   initial begin : driver
      logic [1:0] rm;
      reset_n   = 1'b0;
      enable    = 1'b0;
      mode      = 2'b00;
      j         = 4'h0;
      k         = 4'h0;
      d         = 4'h0;
      serial_in = 1'b0;
      mq        = 4'h0;
      #2 check_reset_now("reset_state");

      // JK per-bit: toggle, set, clear, hold
      step(1'b1, MODE_LOAD, 4'h0, 4'h0, 4'h5, 1'b0, 0);
      step(1'b1, MODE_JK,   4'hC, 4'hA, 4'h0, 1'b0, 0);
      // Load then count through the wrap
      step(1'b1, MODE_LOAD,  4'hF, 4'hF, 4'hE, 1'b1, 0);
      step(1'b1, MODE_COUNT, 4'h3, 4'h5, 4'h1, 1'b1, 0);
      step(1'b1, MODE_COUNT, 4'h3, 4'h5, 4'h1, 1'b1, 0);
      step(1'b1, MODE_JK,    4'h0, 4'h0, 4'h0, 1'b0, 0);
      // Disabled count holds
      step(1'b1, MODE_LOAD,  4'h0, 4'h0, 4'h7, 1'b0, 0);
      step(1'b0, MODE_COUNT, 4'hF, 4'h0, 4'h0, 1'b1, 0);
      step(1'b0, MODE_COUNT, 4'hF, 4'h0, 4'h0, 1'b1, 0);
      step(1'b0, MODE_COUNT, 4'hF, 4'h0, 4'h0, 1'b1, 0);
      // Shift
      step(1'b1, MODE_LOAD,  4'h0, 4'h0, 4'h9, 1'b0, 0);
      step(1'b1, MODE_SHIFT, 4'hF, 4'hF, 4'h0, 1'b1, 0);
      step(1'b1, MODE_SHIFT, 4'hF, 4'hF, 4'hF, 1'b0, 0);
      // Asynchronous reset mid-cycle from q=A
      step(1'b1, MODE_LOAD, 4'h0, 4'h0, 4'hA, 1'b0, 0);
      step(1'b1, MODE_JK,   4'h0, 4'h0, 4'h0, 1'b0, 1);
      // Reset pulsed during a count from F: no carry
      step(1'b1, MODE_LOAD,  4'h0, 4'h0, 4'hF, 1'b0, 0);
      step(1'b1, MODE_COUNT, 4'h0, 4'h0, 4'h0, 1'b0, 1);
      step(1'b1, MODE_JK,    4'h0, 4'h0, 4'h0, 1'b0, 0);
      // Reset held across a counting edge from F
      step(1'b1, MODE_LOAD,  4'h0, 4'h0, 4'hF, 1'b0, 0);
      step(1'b1, MODE_COUNT, 4'h0, 4'h0, 4'h0, 1'b0, 2);
      step(1'b1, MODE_COUNT, 4'h0, 4'h0, 4'h0, 1'b0, 0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rm = 2'($urandom_range(0, 3));
         step(($urandom_range(0, 7) != 0), rm, 4'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      step(1'b0, MODE_JK, 4'h0, 4'h0, 4'h0, 1'b0, 0);

      @(posedge clock);
      #3;
      chk("queue_drained", 32'(exp_fifo.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_jk_register_bank
